// File: rtl/icache_l1.sv
// icache_l1: direct-mapped L1 instruction cache with a zero-cycle hit path and a Wishbone line refill.
module icache_l1 #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_cyc,
    input  logic         cpu_stb,
    input  logic [11:0]  cpu_adr,
    output logic [127:0] cpu_dat_s,
    output logic         cpu_ack,
    output logic         mem_cyc,
    output logic         mem_stb,
    output logic         mem_we,
    output logic [15:0]  mem_sel,
    output logic [11:0]  mem_adr,
    input  logic [127:0] mem_dat_s,
    input  logic         mem_ack,
    input  logic         inv,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 12 - INDEX_BITS;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                  state, state_nxt;
    logic [127:0]            line_q [SETS];
    logic [TAG_W-1:0]        tag_q [SETS];
    logic [SETS-1:0]         valid_q;
    logic [11:0]             refill_adr;
    logic                    inv_flag;
    logic [INDEX_BITS-1:0]   idx, ridx;
    logic [TAG_W-1:0]        tag;
    logic                    req, hit, miss, fill;

    assign mem_we  = 1'b0;
    assign mem_sel = 16'hFFFF;

    always_comb begin
        idx       = cpu_adr[INDEX_BITS-1:0];
        tag       = cpu_adr[11:INDEX_BITS];
        ridx      = refill_adr[INDEX_BITS-1:0];
        req       = cpu_cyc && cpu_stb;
        hit       = state == IDLE && req && valid_q[idx] && tag_q[idx] == tag;
        miss      = state == IDLE && req && !hit;
        fill      = state == FETCH && mem_ack;
        state_nxt = miss ? FETCH : fill ? IDLE : state;
        cpu_ack   = hit;
        cpu_dat_s = hit ? line_q[idx] : '0;
        mem_cyc   = state == FETCH;
        mem_stb   = state == FETCH;
        mem_adr   = state == FETCH ? refill_adr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            refill_adr <= '0;
            inv_flag   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (miss) refill_adr <= cpu_adr;
            // an invalidate seen at any point of a refill keeps the new line invalid
            if (state == IDLE && inv) valid_q <= '0;
            else if (fill) valid_q[ridx] <= !(inv_flag || inv);
            inv_flag <= state == FETCH && !mem_ack && (inv_flag || inv);
            if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            line_q[ridx] <= mem_dat_s;
            tag_q[ridx]  <= refill_adr[11:INDEX_BITS];
        end
    end
endmodule

// File: tb/tb_icache_l1.sv
// tb_icache_l1: directed scenario bench for icache_l1.
module tb_icache_l1;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_cyc, cpu_stb, mem_ack, inv;
    logic [11:0]  cpu_adr;
    logic [127:0] mem_dat_s;
    logic [127:0] cpu_dat_s;
    logic         cpu_ack, mem_cyc, mem_stb, mem_we;
    logic [15:0]  mem_sel, hit_count, miss_count;
    logic [11:0]  mem_adr;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           exp_hit = 0;
    int           exp_miss = 0;

    localparam logic [127:0] PA5 = {16{8'hA5}};
    localparam logic [127:0] PB  = {16{8'hB7}};
    localparam logic [127:0] PC  = {16{8'hC3}};
    localparam logic [127:0] PD  = {16{8'hD9}};
    localparam logic [127:0] PE  = {16{8'hE1}};

    icache_l1 dut (
        .clk(clk), .rst_n(rst_n), .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_adr(cpu_adr),
        .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack), .mem_cyc(mem_cyc), .mem_stb(mem_stb),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_adr(mem_adr), .mem_dat_s(mem_dat_s),
        .mem_ack(mem_ack), .inv(inv), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // miss on a, memory acks on the lat-th FETCH cycle, ends in IDLE with the request dropped
    task automatic refill(input logic [11:0] a, input logic [127:0] d, input int lat);
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = a; exp_miss++;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); mem_ack = (i == lat - 1); mem_dat_s = d;
        end
        @(negedge clk); mem_ack = 0; cpu_cyc = 0; cpu_stb = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b exp 0", cpu_ack); end
        n_cmp++; if (cpu_dat_s !== '0) begin n_bad++; $display("FAIL reset_dat got %h exp 0", cpu_dat_s); end
        n_cmp++; if ({mem_cyc, mem_stb, mem_we} !== 3'b000) begin n_bad++; $display("FAIL reset_mem got %b exp 000", {mem_cyc, mem_stb, mem_we}); end
        n_cmp++; if (mem_adr !== 12'h0 || mem_sel !== 16'hFFFF) begin n_bad++; $display("FAIL reset_adr_sel got %h/%h exp 000/ffff", mem_adr, mem_sel); end
        n_cmp++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got %h/%h exp 0/0", hit_count, miss_count); end
    endtask

    task automatic test_cold_miss();
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h010; #1;
        n_cmp++; if (cpu_ack !== 1'b0 || mem_cyc !== 1'b0) begin n_bad++; $display("FAIL cold_idle ack/cyc got %b%b exp 00", cpu_ack, mem_cyc); end
        exp_miss++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack = (i == 2); mem_dat_s = PA5; #1;
            n_cmp++; if (mem_adr !== 12'h010 || mem_cyc !== 1'b1 || mem_stb !== 1'b1 || cpu_ack !== 1'b0)
                begin n_bad++; $display("FAIL cold_fetch%0d adr %h cyc %b ack %b exp 010 1 0", i, mem_adr, mem_cyc, cpu_ack); end
        end
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PA5) begin n_bad++; $display("FAIL cold_hit ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PA5); end
        exp_hit++;
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0; #1;
        n_cmp++; if (miss_count !== 16'd1 || hit_count !== 16'd1) begin n_bad++; $display("FAIL cold_cnt got %0d/%0d exp 1/1", miss_count, hit_count); end
        n_cmp++; if (cpu_ack !== 1'b0 || cpu_dat_s !== '0) begin n_bad++; $display("FAIL idle_dat ack %b dat %h exp 0 0", cpu_ack, cpu_dat_s); end
    endtask

    task automatic test_no_request();
        @(negedge clk); cpu_cyc = 1; cpu_stb = 0; cpu_adr = 12'h050;
        @(negedge clk); cpu_cyc = 0; cpu_stb = 1; #1;
        n_cmp++; if (mem_cyc !== 1'b0) begin n_bad++; $display("FAIL nostb_fetch got %b exp 0", mem_cyc); end
        @(negedge clk); cpu_stb = 0; cpu_adr = 12'h010; #1;
        n_cmp++; if (mem_cyc !== 1'b0 || miss_count !== 16'(exp_miss)) begin n_bad++; $display("FAIL nocyc got cyc %b miss %0d exp 0 %0d", mem_cyc, miss_count, exp_miss); end
    endtask

    task automatic test_conflict();
        refill(12'h018, PB, 2);
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h018; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PB) begin n_bad++; $display("FAIL conf_hit018 ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PB); end
        exp_hit++;
        @(negedge clk); cpu_adr = 12'h010; #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL conf_miss010 got %b exp 0", cpu_ack); end
        exp_miss++;
        @(negedge clk); mem_ack = 1; mem_dat_s = PA5; #1;
        n_cmp++; if (mem_adr !== 12'h010) begin n_bad++; $display("FAIL conf_adr got %h exp 010", mem_adr); end
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PA5) begin n_bad++; $display("FAIL conf_hit010 ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PA5); end
        exp_hit++;
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0; #1;
        n_cmp++; if (miss_count !== 16'd3) begin n_bad++; $display("FAIL conf_miss_cnt got %0d exp 3", miss_count); end
    endtask

    task automatic test_redirect();
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h020; exp_miss++;
        @(negedge clk); cpu_adr = 12'h031; #1;
        n_cmp++; if (mem_adr !== 12'h020 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL redir_f0 adr %h ack %b exp 020 0", mem_adr, cpu_ack); end
        @(negedge clk); mem_ack = 1; mem_dat_s = PC; #1;
        n_cmp++; if (mem_adr !== 12'h020 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL redir_f1 adr %h ack %b exp 020 0", mem_adr, cpu_ack); end
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b0 || mem_cyc !== 1'b0) begin n_bad++; $display("FAIL redir_idle ack %b cyc %b exp 0 0", cpu_ack, mem_cyc); end
        exp_miss++;
        @(negedge clk); mem_ack = 1; mem_dat_s = PD; #1;
        n_cmp++; if (mem_adr !== 12'h031) begin n_bad++; $display("FAIL redir_adr2 got %h exp 031", mem_adr); end
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PD) begin n_bad++; $display("FAIL redir_hit031 ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PD); end
        exp_hit++;
        @(negedge clk); cpu_adr = 12'h020; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PC) begin n_bad++; $display("FAIL redir_hit020 ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PC); end
        exp_hit++;
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0; #1;
        n_cmp++; if (miss_count !== 16'(exp_miss) || hit_count !== 16'(exp_hit))
            begin n_bad++; $display("FAIL redir_cnt got %0d/%0d exp %0d/%0d", miss_count, hit_count, exp_miss, exp_hit); end
    endtask

    task automatic test_invalidate();
        for (int i = 0; i < 8; i++) refill(12'h100 + 12'(i), {16{8'(8'h10 + i)}}, 1);
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h103; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== {16{8'h13}}) begin n_bad++; $display("FAIL inv_pre ack %b dat %h exp 1 13..", cpu_ack, cpu_dat_s); end
        exp_hit++;
        @(negedge clk); cpu_adr = 12'h105; inv = 1; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== {16{8'h15}}) begin n_bad++; $display("FAIL inv_same ack %b dat %h exp 1 15..", cpu_ack, cpu_dat_s); end
        exp_hit++;
        @(negedge clk); inv = 0; cpu_adr = 12'h102; #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL inv_after got %b exp 0", cpu_ack); end
        exp_miss++;
        @(negedge clk); inv = 1; #1;
        n_cmp++; if (mem_adr !== 12'h102) begin n_bad++; $display("FAIL inv_fetch_adr got %h exp 102", mem_adr); end
        @(negedge clk); inv = 0; mem_ack = 1; mem_dat_s = PE;
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b0 || mem_cyc !== 1'b0) begin n_bad++; $display("FAIL inv_fetch_hit ack %b cyc %b exp 0 0", cpu_ack, mem_cyc); end
        exp_miss++;
        @(negedge clk); mem_ack = 1;
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (cpu_ack !== 1'b1 || cpu_dat_s !== PE) begin n_bad++; $display("FAIL inv_refill ack %b dat %h exp 1 %h", cpu_ack, cpu_dat_s, PE); end
        exp_hit++;
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0; #1;
        n_cmp++; if (miss_count !== 16'(exp_miss) || hit_count !== 16'(exp_hit))
            begin n_bad++; $display("FAIL inv_cnt got %0d/%0d exp %0d/%0d", miss_count, hit_count, exp_miss, exp_hit); end
    endtask

    task automatic test_saturation();
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h102;
        repeat (65540) @(negedge clk);
        #1;
        n_cmp++; if (hit_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hit got %h exp ffff", hit_count); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (hit_count !== 16'hFFFF || cpu_ack !== 1'b1) begin n_bad++; $display("FAIL sat_hold got %h ack %b exp ffff 1", hit_count, cpu_ack); end
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0;
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h0F0;
        @(negedge clk); #1;
        n_cmp++; if (mem_cyc !== 1'b1 || mem_adr !== 12'h0F0) begin n_bad++; $display("FAIL rstf_fetch cyc %b adr %h exp 1 0f0", mem_cyc, mem_adr); end
        #2; rst_n = 0; #1;
        n_cmp++; if (mem_cyc !== 1'b0 || mem_stb !== 1'b0 || mem_adr !== 12'h0) begin n_bad++; $display("FAIL rstf_drop cyc %b stb %b adr %h exp 0 0 000", mem_cyc, mem_stb, mem_adr); end
        n_cmp++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin n_bad++; $display("FAIL rstf_cnt got %h/%h exp 0/0", hit_count, miss_count); end
        @(negedge clk); rst_n = 1; cpu_cyc = 0; cpu_stb = 0;
        @(negedge clk); mem_ack = 1; mem_dat_s = PA5;
        @(negedge clk); mem_ack = 0; #1;
        n_cmp++; if (mem_cyc !== 1'b0 || miss_count !== 16'h0) begin n_bad++; $display("FAIL rstf_stale cyc %b miss %0d exp 0 0", mem_cyc, miss_count); end
        @(negedge clk); cpu_cyc = 1; cpu_stb = 1; cpu_adr = 12'h0F0; #1;
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rstf_nofill got %b exp 0", cpu_ack); end
        @(negedge clk); cpu_cyc = 0; cpu_stb = 0; #1;
        n_cmp++; if (mem_cyc !== 1'b1 || mem_adr !== 12'h0F0 || miss_count !== 16'd1)
            begin n_bad++; $display("FAIL rstf_refetch cyc %b adr %h miss %0d exp 1 0f0 1", mem_cyc, mem_adr, miss_count); end
    endtask

    initial begin
        rst_n = 0; cpu_cyc = 0; cpu_stb = 0; cpu_adr = '0; mem_ack = 0; mem_dat_s = '0; inv = 0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk); rst_n = 1;
        test_cold_miss();
        test_no_request();
        test_conflict();
        test_redirect();
        test_invalidate();
        test_saturation();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_l1.md
ICACHE_L1 -- requirements
Module: icache_l1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows: clk  input  1  single clock, all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 Parameter INDEX_BITS, default 3, gives set-index width; sets = 2^INDEX_BITS; tag width = 12 - INDEX_BITS.
REQ-004 cpu_cyc  input  1  fetch-side Wishbone cycle.
REQ-005 cpu_stb  input  1  fetch-side strobe.
REQ-006 cpu_adr  input  12  line address (byte address bits [15:4]).
REQ-007 cpu_dat_s  output  128  line data returned to the fetch stage.
REQ-008 cpu_ack  output  1  line valid on cpu_dat_s this cycle.
REQ-009 mem_cyc, mem_stb  output  1 each  memory-side cycle and strobe.
REQ-010 mem_we  output  1  constant 0.
REQ-011 mem_sel  output  16  constant 16'hFFFF.
REQ-012 mem_adr  output  12  refill line address.
REQ-013 mem_dat_s  input  128  refill data.
REQ-014 mem_ack  input  1  refill data valid.
REQ-015 inv  input  1  invalidate all lines (single-cycle pulse or level).
REQ-016 hit_count, miss_count  output  16 each  saturating performance counters.

Function
REQ-017 Direct-mapped storage: per set one 128-bit line, one tag, one valid bit; index = cpu_adr[INDEX_BITS-1:0], tag = cpu_adr[11:INDEX_BITS].
REQ-018 FSM states SHALL be IDLE and FETCH only.
REQ-019 In IDLE, hit = cpu_cyc & cpu_stb & valid[index] & (tag match); on hit cpu_ack=1 and cpu_dat_s=line[index] combinationally, same cycle (zero-cycle hit latency).
REQ-020 In IDLE on a request that misses: cpu_ack=0, latch cpu_adr into refill address register, next state FETCH.
REQ-021 In FETCH: mem_cyc=mem_stb=1, mem_adr=latched address; cpu_ack=0 regardless of cpu_adr.
REQ-022 In FETCH on mem_ack: write mem_dat_s, tag and valid=1 into the latched set; next state IDLE; the refilled line is a hit from the following cycle (miss penalty = memory latency + 1 cycle).
REQ-023 cpu_adr changing during FETCH (branch redirect) SHALL NOT abort or retarget the refill; the new address is evaluated in IDLE afterwards.
REQ-024 Outside FETCH, mem_cyc=mem_stb=0 and mem_adr=0.
REQ-025 cpu_dat_s SHALL be 0 whenever cpu_ack=0.
REQ-026 inv in IDLE clears all valid bits at the clock edge; a hit in that same cycle still acks with the old line.
REQ-027 If inv is high in any cycle of a FETCH, the completing refill writes data/tag but leaves valid=0 for that set (invalidate wins); the flag clears on return to IDLE.
REQ-028 hit_count increments by 1 per cycle with a hit ack; miss_count by 1 on each IDLE->FETCH transition; both saturate at 16'hFFFF.
REQ-029 Requests with cpu_cyc=0 or cpu_stb=0 SHALL neither count nor start a refill.

Reset
REQ-030 On rst_n low, immediately and independent of clk: state=IDLE, all valid bits=0, refill address=0, inv flag=0, counters=0, cpu_ack=0, cpu_dat_s=0, mem_cyc=mem_stb=0, mem_adr=0.
REQ-031 Reset during FETCH abandons the refill; a mem_ack arriving after reset release in IDLE SHALL be ignored.
REQ-032 Line data and tag arrays need not be reset.

Verification
REQ-033 Cold miss: reset, cpu_adr=12'h010 held with cyc/stb=1, memory acks after 3 cycles with 128'hA5..A5 -> mem_adr=12'h010 for 3 cycles, one cycle later cpu_ack=1 with A5..A5, miss_count=1, hit_count=1.
REQ-034 Conflict: after line 12'h010 is filled, request 12'h018 (same set 0, different tag) -> miss, refill at 12'h018; re-request 12'h010 -> miss again; miss_count=3.
REQ-035 Redirect: miss on 12'h020, change cpu_adr to 12'h031 during FETCH -> mem_adr stays 12'h020, no cpu_ack until refill completes, then 12'h031 misses and refills.
REQ-036 Invalidate: fill sets 0-7, pulse inv one cycle in IDLE -> next request to any filled address misses; pulse inv during a FETCH -> refilled set still misses afterwards.
REQ-037 Saturation and reset: force 65536 hits -> hit_count=16'hFFFF, stays; assert rst_n low mid-FETCH -> mem_cyc drops same cycle, counters read 0, stale mem_ack after release has no effect.
